// File: rtl/uart_line_checker.sv
// 8N1 UART receiver feeding a matcher for the "Hello World!\r\n" line.
// Reports per-byte, per-frame and per-line status with saturating counters.
module uart_line_checker #(
    parameter int BAUD   = 115200,
    parameter int CLK_HZ = 48000000
) (
    input  logic        clk48,
    input  logic        rst_n,
    input  logic        rx,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        frame_err,
    output logic        line_ok,
    output logic        line_bad,
    output logic [15:0] ok_count,
    output logic [15:0] err_count,
    output logic        synced
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int TW  = $clog2(DIV);
    localparam logic [TW-1:0] T_FULL = TW'(DIV - 1);
    localparam logic [TW-1:0] T_HALF = TW'(DIV / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          rx_meta;
    logic          rx_sync;
    logic [1:0]    warm;
    logic          armed;
    logic [TW-1:0] timer;
    logic          tick;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          load_half;
    logic          load_full;
    logic          take_bit;
    logic          stop_ok;
    logic          stop_bad;
    logic [3:0]    p;
    logic [15:0]   ok_cnt;
    logic [15:0]   err_cnt;

    assign tick      = (timer == '0);
    assign ok_count  = ok_cnt;
    assign err_count = err_cnt;

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Arm only once a genuine high has passed the synchronizer after reset,
    // so a line held low across reset release cannot start a frame.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            warm  <= 2'b00;
            armed <= 1'b0;
        end else begin
            warm  <= {warm[0], 1'b1};
            armed <= armed | (warm[1] & rx_sync);
        end
    end

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      if (armed && !rx_sync) state_nx = START;
            START:     if (tick) state_nx = rx_sync ? IDLE : DATA;
            DATA:      if (tick && bit_idx == 3'd7) state_nx = STOP;
            STOP:      if (tick) state_nx = rx_sync ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_sync) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        load_half = (state == IDLE) && armed && !rx_sync;
        take_bit  = (state == DATA) && tick;
        load_full = ((state == START) && tick) || take_bit;
        stop_ok   = (state == STOP) && tick && rx_sync;
        stop_bad  = (state == STOP) && tick && !rx_sync;
    end

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            timer      <= '0;
            bit_idx    <= 3'd0;
            shift      <= 8'h00;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            byte_data  <= 8'h00;
        end else begin
            if (load_half)      timer <= T_HALF;
            else if (load_full) timer <= T_FULL;
            else if (!tick)     timer <= timer - 1'b1;
            if (state == START) bit_idx <= 3'd0;
            else if (take_bit)  bit_idx <= bit_idx + 3'd1;
            if (take_bit) shift <= {rx_sync, shift[7:1]};
            byte_valid <= stop_ok;
            frame_err  <= stop_bad;
            if (stop_ok) byte_data <= shift;
        end
    end

    function automatic logic [7:0] expect_byte(input logic [3:0] idx);
        logic [7:0] b;
        unique case (idx)
            4'd0:    b = 8'h48;
            4'd1:    b = 8'h65;
            4'd2:    b = 8'h6C;
            4'd3:    b = 8'h6C;
            4'd4:    b = 8'h6F;
            4'd5:    b = 8'h20;
            4'd6:    b = 8'h57;
            4'd7:    b = 8'h6F;
            4'd8:    b = 8'h72;
            4'd9:    b = 8'h6C;
            4'd10:   b = 8'h64;
            4'd11:   b = 8'h21;
            4'd12:   b = 8'h0D;
            4'd13:   b = 8'h0A;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            p        <= 4'd0;
            line_ok  <= 1'b0;
            line_bad <= 1'b0;
            ok_cnt   <= 16'h0000;
            err_cnt  <= 16'h0000;
            synced   <= 1'b0;
        end else begin
            line_ok  <= 1'b0;
            line_bad <= 1'b0;
            if (byte_valid) begin
                if (byte_data == expect_byte(p)) begin
                    if (p == 4'd13) begin
                        line_ok <= 1'b1;
                        synced  <= 1'b1;
                        p       <= 4'd0;
                        if (ok_cnt != 16'hFFFF) ok_cnt <= ok_cnt + 16'd1;
                    end else begin
                        p <= p + 4'd1;
                    end
                end else if (p != 4'd0) begin
                    // A fresh 'H' can open the next line straight away.
                    line_bad <= 1'b1;
                    synced   <= 1'b0;
                    p        <= (byte_data == 8'h48) ? 4'd1 : 4'd0;
                    if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                end
            end else if (frame_err && p != 4'd0) begin
                line_bad <= 1'b1;
                synced   <= 1'b0;
                p        <= 4'd0;
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_line_checker.sv
// Directed bench for uart_line_checker at a reduced clock (16 clocks/bit).
// Pulse monitors run on the falling edge; checks go through one task.
module tb_uart_line_checker;

    localparam int BAUD   = 115200;
    localparam int CLK_HZ = 1843200;
    localparam int DIV    = CLK_HZ / BAUD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        frame_err;
    logic        line_ok;
    logic        line_bad;
    logic [15:0] ok_count;
    logic [15:0] err_count;
    logic        synced;

    int checks = 0;
    int errors = 0;
    int nbv = 0;
    int nfe = 0;
    int nok = 0;
    int nbad = 0;
    int bad_at = 0;
    int overlap = 0;
    int late = 0;
    logic prev_src = 1'b0;

    logic [7:0] hello [14] = '{
        8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
        8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0D, 8'h0A
    };

    uart_line_checker #(
        .BAUD   (BAUD),
        .CLK_HZ (CLK_HZ)
    ) dut (
        .clk48      (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err),
        .line_ok    (line_ok),
        .line_bad   (line_bad),
        .ok_count   (ok_count),
        .err_count  (err_count),
        .synced     (synced)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (byte_valid) nbv++;
            if (frame_err) nfe++;
            if (line_ok) nok++;
            if (line_bad) begin
                nbad++;
                bad_at = nbv;
            end
            if (line_ok && line_bad) overlap++;
            if ((line_ok || line_bad) && !prev_src) late++;
            prev_src = byte_valid | frame_err;
        end else begin
            prev_src = 1'b0;
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int bits);
        rx = 1'b1;
        repeat (bits * DIV) @(negedge clk);
    endtask

    task automatic tx_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic tx_line;
        for (int i = 0; i < 14; i++) tx_byte(hello[i], 1'b1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_bv"}, 32'(byte_valid), 0);
        check({tag, "_fe"}, 32'(frame_err), 0);
        check({tag, "_lok"}, 32'(line_ok), 0);
        check({tag, "_lbad"}, 32'(line_bad), 0);
        check({tag, "_data"}, 32'(byte_data), 0);
        check({tag, "_okc"}, 32'(ok_count), 0);
        check({tag, "_errc"}, 32'(err_count), 0);
        check({tag, "_sync"}, 32'(synced), 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals(tag);
        rst_n = 1'b1;
        idle(2);
    endtask

    int b_bv;
    int b_fe;
    int b_ok;
    int b_bad;

    task automatic snap;
        b_bv  = nbv;
        b_fe  = nfe;
        b_ok  = nok;
        b_bad = nbad;
    endtask

    initial begin
        do_reset("rst0");

        // three lines back-to-back
        snap();
        for (int k = 0; k < 3; k++) tx_line();
        idle(2);
        check("t1_bv", 32'(nbv - b_bv), 42);
        check("t1_lok", 32'(nok - b_ok), 3);
        check("t1_lbad", 32'(nbad - b_bad), 0);
        check("t1_okc", 32'(ok_count), 3);
        check("t1_errc", 32'(err_count), 0);
        check("t1_sync", 32'(synced), 1);
        check("t1_data", 32'(byte_data), 32'h0A);

        // partial line broken by a new 'H'
        do_reset("rst1");
        snap();
        tx_byte(8'h48, 1'b1);
        tx_byte(8'h65, 1'b1);
        tx_byte(8'h6C, 1'b1);
        tx_line();
        idle(2);
        check("t2_lbad", 32'(nbad - b_bad), 1);
        check("t2_badat", 32'(bad_at - b_bv), 4);
        check("t2_lok", 32'(nok - b_ok), 1);
        check("t2_errc", 32'(err_count), 1);
        check("t2_okc", 32'(ok_count), 1);
        check("t2_sync", 32'(synced), 1);

        // frame error while hunting, then a clean byte
        snap();
        tx_byte(8'h55, 1'b0);
        idle(3);
        check("t3_fe", 32'(nfe - b_fe), 1);
        check("t3_bv0", 32'(nbv - b_bv), 0);
        check("t3_errc0", 32'(err_count), 1);
        tx_byte(8'h41, 1'b1);
        idle(2);
        check("t3_bv1", 32'(nbv - b_bv), 1);
        check("t3_data", 32'(byte_data), 32'h41);
        check("t3_lbad0", 32'(nbad - b_bad), 0);

        // frame error inside a partial line
        snap();
        tx_byte(8'h48, 1'b1);
        tx_byte(8'h65, 1'b1);
        tx_byte(8'h6C, 1'b0);
        idle(3);
        check("t3b_bv", 32'(nbv - b_bv), 2);
        check("t3b_fe", 32'(nfe - b_fe), 1);
        check("t3b_lbad", 32'(nbad - b_bad), 1);
        check("t3b_errc", 32'(err_count), 2);
        check("t3b_sync", 32'(synced), 0);

        // short low glitch in idle
        snap();
        rx = 1'b0;
        repeat (DIV / 4) @(negedge clk);
        idle(3);
        check("t4_bv0", 32'(nbv - b_bv), 0);
        check("t4_fe0", 32'(nfe - b_fe), 0);
        tx_byte(8'h5A, 1'b1);
        idle(2);
        check("t4_bv1", 32'(nbv - b_bv), 1);
        check("t4_data", 32'(byte_data), 32'h5A);

        // reset in the middle of bit 4, line held low across release
        rx = 1'b0;
        repeat (5 * DIV + DIV / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        check_reset_vals("t5r");
        rst_n = 1'b1;
        snap();
        repeat (3 * DIV) @(negedge clk);
        idle(3);
        check("t5_bv0", 32'(nbv - b_bv), 0);
        check("t5_fe0", 32'(nfe - b_fe), 0);
        tx_line();
        idle(2);
        check("t5_bv", 32'(nbv - b_bv), 14);
        check("t5_lok", 32'(nok - b_ok), 1);
        check("t5_okc", 32'(ok_count), 1);
        check("t5_sync", 32'(synced), 1);

        // counter saturation from a preloaded value
        force dut.ok_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.ok_cnt;
        snap();
        tx_line();
        idle(2);
        check("t6_okc1", 32'(ok_count), 32'hFFFF);
        tx_line();
        idle(2);
        check("t6_okc2", 32'(ok_count), 32'hFFFF);
        check("t6_lok", 32'(nok - b_ok), 2);

        check("overlap", 32'(overlap), 0);
        check("latency", 32'(late), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_line_checker.md
UART_LINE_CHECKER -- requirements
Module: uart_line_checker

Interface
REQ-001 Parameter BAUD, default 115200, serial bit rate.
REQ-002 Parameter CLK_HZ, default 48000000, clock frequency; bit period DIV = CLK_HZ/BAUD (integer division, 416 at defaults).
REQ-003 clk48  input  1  sole clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rx  input  1  asynchronous serial line, 8N1, idle high.
REQ-006 byte_valid  output  1  one-cycle pulse: byte received with valid stop bit.
REQ-007 byte_data  output  8  last received byte; stable until next byte_valid.
REQ-008 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 line_ok  output  1  one-cycle pulse: complete "Hello World!\r\n" matched.
REQ-010 line_bad  output  1  one-cycle pulse: partially matched line broken.
REQ-011 ok_count  output  16  saturating count of line_ok pulses.
REQ-012 err_count  output  16  saturating count of line_bad pulses.
REQ-013 synced  output  1  high from first line_ok until next line_bad.

Function
REQ-014 rx shall pass through a 2-flop synchronizer; all receiver logic uses the synchronized value.
REQ-015 Receiver FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-016 IDLE -> START on synchronized rx low; bit timer loaded to sample at DIV/2.
REQ-017 START: at DIV/2, rx low -> DATA; rx high -> IDLE (glitch, no output pulse).
REQ-018 DATA: sample 8 bits every DIV cycles, LSB first, into shift register; after bit 7 -> STOP.
REQ-019 STOP: sample DIV cycles after bit 7; high -> byte_valid pulse next cycle, byte_data updated same cycle, -> IDLE; low -> frame_err pulse, -> WAIT_HIGH.
REQ-020 WAIT_HIGH -> IDLE when synchronized rx high (break/line-low condition does not generate repeated frames).
REQ-021 Checker holds index p, 0..13; expected sequence 0x48 65 6C 6C 6F 20 57 6F 72 6C 64 21 0D 0A.
REQ-022 On byte_valid with byte == expected[p]: p==13 -> line_ok pulse, ok_count+1, synced=1, p=0; else p=p+1.
REQ-023 On byte_valid mismatch with p!=0: line_bad pulse, err_count+1, synced=0; then p=1 if byte==0x48, else p=0.
REQ-024 On byte_valid mismatch with p==0: no pulse, no count change (hunting).
REQ-025 On frame_err with p!=0: line_bad pulse, err_count+1, synced=0, p=0; with p==0: no checker effect.
REQ-026 line_ok/line_bad shall assert exactly one cycle after the byte_valid/frame_err pulse causing them; never both in one cycle.
REQ-027 Counters saturate at 0xFFFF; no wrap.
REQ-028 No flow control: bytes arriving back-to-back at line rate (stop bit directly followed by start bit) shall all be received.

Reset
REQ-029 While rst_n low: FSM=IDLE, synchronizer flops=1, p=0, byte_data=0, byte_valid=frame_err=line_ok=line_bad=0, ok_count=err_count=0, synced=0.
REQ-030 Reset asserted mid-byte discards the partial byte; after release the receiver waits for a fresh high-to-low transition before starting (rx held low at release does not start a frame).

Verification
REQ-031 Send "Hello World!\r\n" three times back-to-back at 115200 -> 42 byte_valid, 3 line_ok, ok_count=3, err_count=0, synced=1.
REQ-032 Send "Hel" then "Hello World!\r\n" -> one line_bad on second 'H' byte, then line_ok; err_count=1, ok_count=1, synced=1.
REQ-033 Send 0x55 with stop bit low, then line high -> one frame_err, no byte_valid, then 0x41 received correctly with byte_data=0x41.
REQ-034 rx low pulse of DIV/4 cycles in idle -> no byte_valid, no frame_err; next valid byte received normally.
REQ-035 Assert rst_n low midway through bit 4 of a byte, release after 10 cycles -> all outputs at reset values, next full line yields line_ok with ok_count=1.
REQ-036 Preload ok_count near 0xFFFF via 0xFFFF+2 matched lines (or forced state) -> ok_count holds 0xFFFF, no wrap.
